// File: rtl/pcs_seq_pkg.sv
// Shared types and constants for the PCS generator run-time sequencer.
package pcs_seq_pkg;

   localparam int PCS_SEQ_CNT_WIDTH = 16;  // default width of the phase counters
   localparam int PCS_SEQ_LANES     = 2;   // one lane per PCS generator

   typedef enum logic [2:0] {
      IDLE,
      RANDOM,
      SWEEP,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/pcs_seq_cycle_counter.sv
// Loadable down-counter shared by the random, dwell and drain phases.
// A load of N gives exactly N cycles: the count runs N..1 and o_tc marks the
// last of them. The count parks at 0 when no phase is running.
module pcs_seq_cycle_counter
   import pcs_seq_pkg::*;
#(
   parameter int CNT_WIDTH = PCS_SEQ_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic [CNT_WIDTH-1:0] i_load_val,
   output logic                 o_tc
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   // Next count: a load wins, otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tc = (cnt_q == CNT_WIDTH'(1));

endmodule

// File: rtl/pcs_gen_sequencer.sv
// Run-time controller for the PCS generator: random phase, select-code sweep,
// drain, then a done pulse. All outputs are registered and are decoded from
// the next state, so a start in cycle n shows o_valid in cycle n+1.
module pcs_gen_sequencer
   import pcs_seq_pkg::*;
#(
   parameter int TRANSCODER_BLOCKS = 4,
   parameter int CNT_WIDTH         = PCS_SEQ_CNT_WIDTH,
   parameter int DRAIN_CYCLES      = 8
) (
   input  logic                         clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic                         i_abort,
   input  logic [CNT_WIDTH-1:0]         i_random_cycles,
   input  logic [CNT_WIDTH-1:0]         i_dwell_cycles,
   input  logic [TRANSCODER_BLOCKS-1:0] i_sel_first,
   input  logic [TRANSCODER_BLOCKS-1:0] i_sel_last,
   input  logic [PCS_SEQ_LANES-1:0]     i_lane_en,
   output logic                         o_valid,
   output logic                         o_random_0,
   output logic                         o_random_1,
   output logic [TRANSCODER_BLOCKS-1:0] o_data_sel_0,
   output logic [TRANSCODER_BLOCKS-1:0] o_data_sel_1,
   output logic                         o_sel_strobe,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_aborted
);

   localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_CYCLES);

   state_t                       state_q, state_d;
   logic [TRANSCODER_BLOCKS-1:0] sel_q, sel_d;
   // configuration latched at start; the random length is consumed at start
   logic [CNT_WIDTH-1:0]         dwell_q, dwell_d;
   logic [TRANSCODER_BLOCKS-1:0] last_q, last_d;
   logic [TRANSCODER_BLOCKS-1:0] first_q, first_d;
   logic [PCS_SEQ_LANES-1:0]     lane_q, lane_d;
   // output registers
   logic                         valid_q, valid_d;
   logic [PCS_SEQ_LANES-1:0]     random_q, random_d;
   logic [TRANSCODER_BLOCKS-1:0] dsel0_q, dsel0_d;
   logic [TRANSCODER_BLOCKS-1:0] dsel1_q, dsel1_d;
   logic                         strobe_q, strobe_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         aborted_q, aborted_d;
   // phase counter control
   logic                         cnt_load;
   logic [CNT_WIDTH-1:0]         cnt_load_val;
   logic                         cnt_tc;

   pcs_seq_cycle_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_cnt (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_load     (cnt_load),
      .i_load_val (cnt_load_val),
      .o_tc       (cnt_tc)
   );

   // Next state, config latch, sel register, counter control and output decode.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      dwell_d      = dwell_q;
      first_d      = first_q;
      last_d       = last_q;
      lane_d       = lane_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      aborted_d    = 1'b0;

      if ((state_q != IDLE) && i_abort) begin
         state_d   = IDLE;
         aborted_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  dwell_d = i_dwell_cycles;
                  first_d = i_sel_first;
                  last_d  = i_sel_last;
                  lane_d  = i_lane_en;
                  if (i_random_cycles != '0) begin
                     state_d      = RANDOM;
                     cnt_load     = 1'b1;
                     cnt_load_val = i_random_cycles;
                  end else begin
                     state_d      = SWEEP;
                     sel_d        = i_sel_first;
                     cnt_load     = 1'b1;
                     cnt_load_val = (i_dwell_cycles == '0) ? CNT_WIDTH'(1) : i_dwell_cycles;
                  end
               end
            end
            RANDOM: begin
               if (cnt_tc) begin
                  state_d      = SWEEP;
                  sel_d        = first_q;
                  cnt_load     = 1'b1;
                  cnt_load_val = (dwell_q == '0) ? CNT_WIDTH'(1) : dwell_q;
               end
            end
            SWEEP: begin
               if (cnt_tc) begin
                  if (sel_q == last_q) begin
                     state_d      = DRAIN;
                     cnt_load     = 1'b1;
                     cnt_load_val = DRAIN_LOAD;
                  end else begin
                     // modulo-2^TRANSCODER_BLOCKS increment wraps through 0
                     sel_d        = sel_q + TRANSCODER_BLOCKS'(1);
                     cnt_load     = 1'b1;
                     cnt_load_val = (dwell_q == '0) ? CNT_WIDTH'(1) : dwell_q;
                  end
               end
            end
            DRAIN: begin
               if (cnt_tc) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // outputs follow the state being entered
      valid_d  = (state_d == RANDOM) || (state_d == SWEEP);
      random_d = (state_d == RANDOM) ? lane_d : '0;
      dsel0_d  = ((state_d == SWEEP) && lane_d[0]) ? sel_d : '0;
      dsel1_d  = ((state_d == SWEEP) && lane_d[1]) ? sel_d : '0;
      // every entry into a code reloads the dwell counter
      strobe_d = (state_d == SWEEP) && cnt_load;
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
   end

   // FSM state, configuration and output registers.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         dwell_q   <= '0;
         first_q   <= '0;
         last_q    <= '0;
         lane_q    <= '0;
         valid_q   <= 1'b0;
         random_q  <= '0;
         dsel0_q   <= '0;
         dsel1_q   <= '0;
         strobe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         dwell_q   <= dwell_d;
         first_q   <= first_d;
         last_q    <= last_d;
         lane_q    <= lane_d;
         valid_q   <= valid_d;
         random_q  <= random_d;
         dsel0_q   <= dsel0_d;
         dsel1_q   <= dsel1_d;
         strobe_q  <= strobe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign o_valid      = valid_q;
   assign o_random_0   = random_q[0];
   assign o_random_1   = random_q[1];
   assign o_data_sel_0 = dsel0_q;
   assign o_data_sel_1 = dsel1_q;
   assign o_sel_strobe = strobe_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_aborted    = aborted_q;

endmodule
